// File: rtl/rule_range_match.sv
// node_pkg: packet/rule structs shared across the tree classifier.
// rule_range_match: per-field unsigned range compare of a 5-tuple plus a one-cycle registered copy.
package node_pkg;
    typedef struct packed {
        logic [31:0] ip;
        logic [15:0] port;
    } endpoint_s;

    typedef struct packed {
        endpoint_s   src;
        endpoint_s   dst;
        logic [7:0]  protocol;
    } packet_s;

    typedef struct packed {
        packet_s     start;
        packet_s     last;
        logic [31:0] weight;
    } rule_s;
endpackage

module rule_range_match
    import node_pkg::*;
#(
    parameter bit LAST_ZERO_IS_MAX = 1'b1
) (
    input  logic    clk,
    input  logic    reset,
    input  rule_s   rule,
    input  packet_s packet,
    input  logic    valid_in,
    output logic    matched,
    output logic [4:0] field_matched,
    output logic    matched_q,
    output logic    valid_q
);
    logic matched_d;
    logic valid_d;
    logic unused_weight;

    // Narrow fields are zero-extended, which keeps the unsigned order and the last==0 test intact.
    function automatic logic in_range(input logic [31:0] v, input logic [31:0] s, input logic [31:0] l);
        return (v >= s) && ((v < l) || (LAST_ZERO_IS_MAX && (l == 32'd0)));
    endfunction

    assign unused_weight = ^rule.weight;

    always_comb begin
        field_matched[4] = in_range(packet.src.ip, rule.start.src.ip, rule.last.src.ip);
        field_matched[3] = in_range(packet.dst.ip, rule.start.dst.ip, rule.last.dst.ip);
        field_matched[2] = in_range(32'(packet.src.port), 32'(rule.start.src.port), 32'(rule.last.src.port));
        field_matched[1] = in_range(32'(packet.dst.port), 32'(rule.start.dst.port), 32'(rule.last.dst.port));
        field_matched[0] = in_range(32'(packet.protocol), 32'(rule.start.protocol), 32'(rule.last.protocol));
        matched = &field_matched;
        matched_d = valid_in & matched;
        valid_d = valid_in;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            matched_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            matched_q <= matched_d;
            valid_q <= valid_d;
        end
    end
endmodule

// File: tb/tb_rule_range_match.sv
// tb_rule_range_match: directed vector table, registered-path sequences and random compare against a range model.
module tb_rule_range_match;
    import node_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    rule_s      rule;
    packet_s    packet;
    logic       valid_in;
    logic       matched;
    logic [4:0] field_matched;
    logic       matched_q;
    logic       valid_q;

    int passed = 0;
    int total = 0;

    rule_range_match #(.LAST_ZERO_IS_MAX(1'b1)) dut (
        .clk(clk),
        .reset(reset),
        .rule(rule),
        .packet(packet),
        .valid_in(valid_in),
        .matched(matched),
        .field_matched(field_matched),
        .matched_q(matched_q),
        .valid_q(valid_q)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        rule_s      r;
        packet_s    p;
        logic [4:0] fm;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        else passed++;
    endtask

    // Interval model: a field of width w matches when start <= v < end, end being 2^w when last is 0.
    function automatic bit fld_ok(input longint v, input longint s, input longint l, input int w);
        longint hi;
        hi = (l == 0) ? (longint'(1) << w) : l;
        return (v >= s) && (v < hi);
    endfunction

    function automatic logic [4:0] ref_fm(input rule_s r, input packet_s p);
        ref_fm[4] = fld_ok(p.src.ip, r.start.src.ip, r.last.src.ip, 32);
        ref_fm[3] = fld_ok(p.dst.ip, r.start.dst.ip, r.last.dst.ip, 32);
        ref_fm[2] = fld_ok(p.src.port, r.start.src.port, r.last.src.port, 16);
        ref_fm[1] = fld_ok(p.dst.port, r.start.dst.port, r.last.dst.port, 16);
        ref_fm[0] = fld_ok(p.protocol, r.start.protocol, r.last.protocol, 8);
    endfunction

    task automatic rand_field(input int w, output logic [31:0] s, output logic [31:0] l, output logic [31:0] v);
        logic [31:0] mask;
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
        s = $urandom & mask;
        case ($urandom_range(0, 3))
            0: l = 32'd0;
            1: l = $urandom & mask;
            2: l = (s + $urandom_range(1, 8)) & mask;
            default: l = s;
        endcase
        case ($urandom_range(0, 3))
            0: v = (s + $urandom_range(0, 8)) & mask;
            1: v = (l - $urandom_range(0, 1)) & mask;
            2: v = (s - 32'd1) & mask;
            default: v = $urandom & mask;
        endcase
    endtask

    task automatic rand_pair(output rule_s r, output packet_s p);
        logic [31:0] s, l, v;
        rand_field(32, s, l, v); r.start.src.ip = s; r.last.src.ip = l; p.src.ip = v;
        rand_field(32, s, l, v); r.start.dst.ip = s; r.last.dst.ip = l; p.dst.ip = v;
        rand_field(16, s, l, v); r.start.src.port = s[15:0]; r.last.src.port = l[15:0]; p.src.port = v[15:0];
        rand_field(16, s, l, v); r.start.dst.port = s[15:0]; r.last.dst.port = l[15:0]; p.dst.port = v[15:0];
        rand_field(8, s, l, v); r.start.protocol = s[7:0]; r.last.protocol = l[7:0]; p.protocol = v[7:0];
        r.weight = $urandom;
    endtask

    task automatic add_vec(input string nm, input rule_s r, input packet_s p, input logic [4:0] fm);
        vec_t v;
        v.name = nm; v.r = r; v.p = p; v.fm = fm;
        vecs.push_back(v);
    endtask

    initial begin
        rule_s   full, r;
        packet_s p;
        logic [4:0] efm;
        logic       exp_mq;

        full = '0;
        reset = 1'b1;
        valid_in = 1'b0;
        rule = full;
        packet = '0;

        p = '1;
        add_vec("full_range", full, p, 5'b11111);
        r = full; r.start.src.ip = 32'h0A00_0000; r.last.src.ip = 32'h0A00_0100;
        p = '0; p.src.ip = 32'h0A00_0000; add_vec("sip_lo", r, p, 5'b11111);
        p.src.ip = 32'h0A00_00FF; add_vec("sip_hi", r, p, 5'b11111);
        p.src.ip = 32'h0A00_0100; add_vec("sip_last", r, p, 5'b01111);
        p.src.ip = 32'h09FF_FFFF; add_vec("sip_below", r, p, 5'b01111);
        r = full; r.start.protocol = 8'd6; r.last.protocol = 8'd7;
        p = '0; p.protocol = 8'd6; add_vec("proto_6", r, p, 5'b11111);
        p.protocol = 8'd17; add_vec("proto_17", r, p, 5'b11110);
        r = full; r.start.dst.port = 16'd80; r.last.dst.port = 16'd80;
        p = '0; p.dst.port = 16'd80; add_vec("empty_80", r, p, 5'b11101);
        p.dst.port = 16'd79; add_vec("empty_79", r, p, 5'b11101);
        r.weight = 32'hFFFF_FFFF; add_vec("empty_wmax", r, p, 5'b11101);
        r = full; r.weight = 32'hFFFF_FFFF; p = '1; add_vec("full_wmax", r, p, 5'b11111);
        r = full; r.start.dst.ip = 32'hFFFF_FFFF; p = '1; add_vec("dip_top_open", r, p, 5'b11111);
        r = full; r.start.src.port = 16'd1000; r.last.src.port = 16'd2000;
        p = '0; p.src.port = 16'd1999; add_vec("sport_in", r, p, 5'b11111);
        p.src.port = 16'd2000; add_vec("sport_out", r, p, 5'b11011);

        foreach (vecs[i]) begin
            rule = vecs[i].r;
            packet = vecs[i].p;
            #1;
            chk({vecs[i].name, "_fm"}, 32'(field_matched), 32'(vecs[i].fm));
            chk({vecs[i].name, "_m"}, 32'(matched), 32'(&vecs[i].fm));
        end

        rule = full; packet = '1; valid_in = 1'b1; reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid_q", 32'(valid_q), 32'd0);
        chk("rst_matched_q", 32'(matched_q), 32'd0);
        chk("rst_comb_matched", 32'(matched), 32'd1);
        @(negedge clk); reset = 1'b0; valid_in = 1'b1;
        @(posedge clk); #1;
        chk("v1_valid_q", 32'(valid_q), 32'd1);
        chk("v1_matched_q", 32'(matched_q), 32'd1);
        @(negedge clk); valid_in = 1'b0;
        @(posedge clk); #1;
        chk("v0_valid_q", 32'(valid_q), 32'd0);
        chk("v0_matched_q", 32'(matched_q), 32'd0);
        @(negedge clk); valid_in = 1'b1; packet.protocol = 8'd0; rule.start.protocol = 8'd5;
        @(posedge clk); #1;
        chk("nomatch_valid_q", 32'(valid_q), 32'd1);
        chk("nomatch_matched_q", 32'(matched_q), 32'd0);
        @(negedge clk); rule = full; packet = '1; valid_in = 1'b1;
        @(posedge clk); #1;
        chk("b2b_matched_q", 32'(matched_q), 32'd1);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        chk("midrst_valid_q", 32'(valid_q), 32'd0);
        chk("midrst_matched_q", 32'(matched_q), 32'd0);
        @(negedge clk); reset = 1'b0;

        for (int n = 0; n < 10000; n++) begin
            @(negedge clk);
            rand_pair(r, p);
            rule = r;
            packet = p;
            valid_in = ($urandom_range(0, 3) != 0);
            efm = ref_fm(r, p);
            exp_mq = valid_in & (&efm);
            #1;
            chk("rand_fm", 32'(field_matched), 32'(efm));
            chk("rand_m", 32'(matched), 32'(&efm));
            @(posedge clk); #1;
            chk("rand_mq", 32'(matched_q), 32'(exp_mq));
            chk("rand_vq", 32'(valid_q), 32'(valid_in));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
